ahb_split_slave_ctrl: RTL and testbench

AHB_SPLIT_SLAVE_CTRL -- requirements
Module: ahb_split_slave_ctrl

---
 rtl/ahb_split_slave_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ahb_split_slave_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_split_slave_ctrl.sv
// AHB slave front-end that splits masters while its backend is busy and
// releases them round-robin through hsplitx once the backend frees up.
module ahb_split_slave_ctrl #(
    parameter int NM    = 5,
    parameter int RELTO = 8
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [1:0]    htrans,
    input  logic          hready,
    input  logic [NM-1:0] hmaster,
    input  logic          hmastlock,
    input  logic          be_done,
    output logic          hreadyout,
    output logic [1:0]    hresp,
    output logic [NM-1:0] hsplitx,
    output logic          be_start,
    output logic [NM-1:0] split_pending
);

    localparam int RW = (NM > 1) ? $clog2(NM) : 1;

    localparam logic [1:0] HR_OKAY  = 2'b00;
    localparam logic [1:0] HR_ERROR = 2'b01;
    localparam logic [1:0] HR_SPLIT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SPLIT1,
        SPLIT2,
        LWAIT,
        ERR1,
        ERR2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          busy_q;
    logic [NM-1:0] mask_q;
    logic [NM-1:0] mask_d;
    logic [RW-1:0] rr_q;
    logic          rel_out_q;
    logic [7:0]    cnt_q;
    logic [NM-1:0] hsplitx_q;
    logic          be_start_q;

    logic          valid;
    logic          onehot;
    logic          busy_eff;
    logic          launch;
    logic          lw_go;
    logic          split_set;
    logic          rel_hit;
    logic [RW-1:0] rel_idx;
    logic          rel_go;
    int            j;

    assign valid    = hsel & hready & ((htrans == 2'b10) | (htrans == 2'b11));
    assign onehot   = (hmaster != '0) &&
                      ((hmaster & (hmaster - NM'(1))) == '0);
    // A completion in this cycle frees the backend for a same-cycle request.
    assign busy_eff = busy_q & ~be_done;

    always_comb begin
        rel_hit = 1'b0;
        rel_idx = '0;
        j       = 0;
        for (int i = 0; i < NM; i++) begin
            j = int'(rr_q) + i;
            if (j >= NM) j = j - NM;
            if (!rel_hit && mask_q[j]) begin
                rel_hit = 1'b1;
                rel_idx = RW'(j);
            end
        end
    end

    assign rel_go = (state_q == IDLE) & ~busy_eff & rel_hit &
                    ~rel_out_q & ~valid;

    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = HR_OKAY;
        launch    = 1'b0;
        lw_go     = 1'b0;
        split_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    if (!onehot) begin
                        state_d = ERR1;
                    end else if (!busy_eff) begin
                        launch = 1'b1;
                    end else if (hmastlock) begin
                        state_d = LWAIT;
                    end else begin
                        state_d   = SPLIT1;
                        split_set = 1'b1;
                    end
                end
            end
            SPLIT1: begin
                hreadyout = 1'b0;
                hresp     = HR_SPLIT;
                state_d   = SPLIT2;
            end
            SPLIT2: begin
                hresp   = HR_SPLIT;
                state_d = IDLE;
            end
            LWAIT: begin
                if (busy_eff) begin
                    hreadyout = 1'b0;
                end else begin
                    lw_go   = 1'b1;
                    state_d = IDLE;
                end
            end
            ERR1: begin
                hreadyout = 1'b0;
                hresp     = HR_ERROR;
                state_d   = ERR2;
            end
            ERR2: begin
                hresp   = HR_ERROR;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d = mask_q;
        if (split_set) mask_d = mask_q | hmaster;
        if (rel_go)    mask_d = mask_q & ~(NM'(1) << rel_idx);
    end

    // Locked transfers launch combinationally in the cycle the backend frees.
    assign be_start      = be_start_q | lw_go;
    assign hsplitx       = hsplitx_q;
    assign split_pending = mask_q;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            mask_q     <= '0;
            rr_q       <= '0;
            rel_out_q  <= 1'b0;
            cnt_q      <= '0;
            hsplitx_q  <= '0;
            be_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            be_start_q <= launch;
            hsplitx_q  <= rel_go ? (NM'(1) << rel_idx) : '0;

            if (launch | lw_go) busy_q <= 1'b1;
            else if (be_done)   busy_q <= 1'b0;

            if (rel_go) begin
                rr_q <= (rel_idx == RW'(NM - 1)) ? '0 : rel_idx + RW'(1);
            end

            if (rel_go) begin
                rel_out_q <= 1'b1;
                cnt_q     <= '0;
            end else if (rel_out_q) begin
                if (be_start || cnt_q == 8'(RELTO - 1)) begin
                    rel_out_q <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_split_slave_ctrl.sv
// Directed bench for ahb_split_slave_ctrl: per-cycle expected outputs are
// queued as each cycle is driven and popped when the outputs settle.
module tb_ahb_split_slave_ctrl;

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SP = 2'b11;
    localparam logic [1:0] ER = 2'b01;
    localparam logic [1:0] OK = 2'b00;

    logic       hclk = 1'b0;
    logic       hreset;
    logic       hsel;
    logic [1:0] htrans;
    logic       hready;
    logic [4:0] hmaster;
    logic       hmastlock;
    logic       be_done;
    logic       hreadyout;
    logic [1:0] hresp;
    logic [4:0] hsplitx;
    logic       be_start;
    logic [4:0] split_pending;

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    ahb_split_slave_ctrl #(.NM(5), .RELTO(8)) dut (
        .hclk          (hclk),
        .hreset        (hreset),
        .hsel          (hsel),
        .htrans        (htrans),
        .hready        (hready),
        .hmaster       (hmaster),
        .hmastlock     (hmastlock),
        .be_done       (be_done),
        .hreadyout     (hreadyout),
        .hresp         (hresp),
        .hsplitx       (hsplitx),
        .be_start      (be_start),
        .split_pending (split_pending)
    );

    always #5 hclk = ~hclk;

    function automatic logic [13:0] e(input logic r, input logic [1:0] rs,
                                      input logic bs, input logic [4:0] sx,
                                      input logic [4:0] sp);
        return {r, rs, bs, sx, sp};
    endfunction

    task automatic push(input string tag, input logic [13:0] ex);
        exp_t x;
        x.tag = tag;
        x.v   = ex;
        q.push_back(x);
    endtask

    task automatic check();
        exp_t        x;
        logic [13:0] obs;
        x   = q.pop_front();
        obs = {hreadyout, hresp, be_start, hsplitx, split_pending};
        n_cmp++;
        assert (obs === x.v) else begin
            n_fail++;
            $error("FAIL %s: rdy/resp/bs/hsplitx/pend got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                   x.tag, obs[13], obs[12:11], obs[10], obs[9:5], obs[4:0],
                   x.v[13], x.v[12:11], x.v[10], x.v[9:5], x.v[4:0]);
        end
    endtask

    task automatic drive(input logic sel, input logic [1:0] tr,
                         input logic [4:0] m, input logic lk, input logic dn);
        hsel      = sel;
        htrans    = tr;
        hmaster   = m;
        hmastlock = lk;
        be_done   = dn;
    endtask

    task automatic cyc(input string tag, input logic sel, input logic [1:0] tr,
                       input logic [4:0] m, input logic lk, input logic dn,
                       input logic [13:0] ex);
        drive(sel, tr, m, lk, dn);
        push(tag, ex);
        @(negedge hclk);
        check();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [13:0] ex);
        cyc(tag, 1'b0, 2'b00, 5'b0, 1'b0, 1'b0, ex);
    endtask

    task automatic done(input string tag, input logic [13:0] ex);
        cyc(tag, 1'b0, 2'b00, 5'b0, 1'b0, 1'b1, ex);
    endtask

    task automatic trn(input string tag, input logic [4:0] m,
                       input logic [13:0] ex);
        cyc(tag, 1'b1, NS, m, 1'b0, 1'b0, ex);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hreset = 1'b1;
        hready = 1'b1;
        drive(1'b0, 2'b00, 5'b0, 1'b0, 1'b0);
        repeat (2) @(posedge hclk);
        #1;
        push("reset", e(1, OK, 0, 5'b0, 5'b0));
        @(negedge hclk);
        check();
        @(posedge hclk);
        #1;
        hreset = 1'b0;

        idle("idle0",     e(1, OK, 0, 5'b0, 5'b0));
        trn ("acc_a",     5'b00100, e(1, OK, 0, 5'b0, 5'b0));
        idle("acc_d",     e(1, OK, 1, 5'b0, 5'b0));
        idle("busy_idle", e(1, OK, 0, 5'b0, 5'b0));
        trn ("spl_a",     5'b01000, e(1, OK, 0, 5'b0, 5'b0));
        idle("spl_1",     e(0, SP, 0, 5'b0, 5'b01000));
        idle("spl_2",     e(1, SP, 0, 5'b0, 5'b01000));
        idle("pend",      e(1, OK, 0, 5'b0, 5'b01000));
        cyc ("done_acc", 1'b1, NS, 5'b00100, 1'b0, 1'b1,
             e(1, OK, 0, 5'b0, 5'b01000));
        idle("defer_bs",  e(1, OK, 1, 5'b0, 5'b01000));
        done("done2",     e(1, OK, 0, 5'b0, 5'b01000));
        idle("rel_a",     e(1, OK, 0, 5'b01000, 5'b0));
        idle("rel_off",   e(1, OK, 0, 5'b0, 5'b0));

        trn ("acc2_a",    5'b00010, e(1, OK, 0, 5'b0, 5'b0));
        idle("acc2_d",    e(1, OK, 1, 5'b0, 5'b0));
        trn ("rr0_a",     5'b00001, e(1, OK, 0, 5'b0, 5'b0));
        idle("rr0_1",     e(0, SP, 0, 5'b0, 5'b00001));
        idle("rr0_2",     e(1, SP, 0, 5'b0, 5'b00001));
        done("rr0_done",  e(1, OK, 0, 5'b0, 5'b00001));
        idle("rr0_rel",   e(1, OK, 0, 5'b00001, 5'b0));
        trn ("acc3_a",    5'b00001, e(1, OK, 0, 5'b0, 5'b0));
        idle("acc3_d",    e(1, OK, 1, 5'b0, 5'b0));
        trn ("rrA_a",     5'b00001, e(1, OK, 0, 5'b0, 5'b0));
        idle("rrA_1",     e(0, SP, 0, 5'b0, 5'b00001));
        idle("rrA_2",     e(1, SP, 0, 5'b0, 5'b00001));
        trn ("rrB_a",     5'b10000, e(1, OK, 0, 5'b0, 5'b00001));
        idle("rrB_1",     e(0, SP, 0, 5'b0, 5'b10001));
        idle("rrB_2",     e(1, SP, 0, 5'b0, 5'b10001));
        done("rr_done",   e(1, OK, 0, 5'b0, 5'b10001));
        idle("rr_rel1",   e(1, OK, 0, 5'b10000, 5'b00001));
        for (int i = 0; i < 7; i++)
            idle("rr_hold", e(1, OK, 0, 5'b0, 5'b00001));
        idle("rr_wait",   e(1, OK, 0, 5'b0, 5'b00001));
        idle("rr_rel2",   e(1, OK, 0, 5'b00001, 5'b0));

        trn ("lk_acc_a",  5'b00010, e(1, OK, 0, 5'b0, 5'b0));
        idle("lk_acc_d",  e(1, OK, 1, 5'b0, 5'b0));
        cyc ("lk_a", 1'b1, NS, 5'b00010, 1'b1, 1'b0,
             e(1, OK, 0, 5'b0, 5'b0));
        idle("lk_w1",     e(0, OK, 0, 5'b0, 5'b0));
        idle("lk_w2",     e(0, OK, 0, 5'b0, 5'b0));
        done("lk_go",     e(1, OK, 1, 5'b0, 5'b0));
        idle("lk_busy",   e(1, OK, 0, 5'b0, 5'b0));
        done("lk_done",   e(1, OK, 0, 5'b0, 5'b0));

        trn ("il0_a",     5'b00000, e(1, OK, 0, 5'b0, 5'b0));
        idle("il0_1",     e(0, ER, 0, 5'b0, 5'b0));
        idle("il0_2",     e(1, ER, 0, 5'b0, 5'b0));
        trn ("il2_a",     5'b00110, e(1, OK, 0, 5'b0, 5'b0));
        idle("il2_1",     e(0, ER, 0, 5'b0, 5'b0));
        idle("il2_2",     e(1, ER, 0, 5'b0, 5'b0));
        idle("il_end",    e(1, OK, 0, 5'b0, 5'b0));

        cyc ("busy_tr", 1'b1, 2'b01, 5'b00100, 1'b0, 1'b0,
             e(1, OK, 0, 5'b0, 5'b0));
        idle("busy_tr_d", e(1, OK, 0, 5'b0, 5'b0));
        hready = 1'b0;
        trn ("nrdy_a",    5'b00100, e(1, OK, 0, 5'b0, 5'b0));
        hready = 1'b1;
        idle("nrdy_d",    e(1, OK, 0, 5'b0, 5'b0));

        trn ("rs_acc_a",  5'b00001, e(1, OK, 0, 5'b0, 5'b0));
        idle("rs_acc_d",  e(1, OK, 1, 5'b0, 5'b0));
        trn ("rs_s1_a",   5'b00010, e(1, OK, 0, 5'b0, 5'b0));
        idle("rs_s1_1",   e(0, SP, 0, 5'b0, 5'b00010));
        idle("rs_s1_2",   e(1, SP, 0, 5'b0, 5'b00010));
        trn ("rs_s2_a",   5'b00100, e(1, OK, 0, 5'b0, 5'b00010));
        drive(1'b0, 2'b00, 5'b0, 1'b0, 1'b0);
        push("rs_s2_1", e(0, SP, 0, 5'b0, 5'b00110));
        @(negedge hclk);
        check();
        #2;
        hreset = 1'b1;
        #1;
        push("rs_async", e(1, OK, 0, 5'b0, 5'b0));
        check();
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        done("rs_done_ign", e(1, OK, 0, 5'b0, 5'b0));
        for (int i = 0; i < 10; i++)
            idle("rs_after", e(1, OK, 0, 5'b0, 5'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
